// File: rtl/adjust_pkg.sv
// rtl/adjust_pkg.sv - shared types and constants for the alarm-clock adjust controller
package adjust_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2,
    ST_LOCK   = 2'd3
  } adj_state_e;

  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } adj_dir_e;

  localparam int unsigned TGT_TIME  = 0;
  localparam int unsigned TGT_ALARM = 1;

  // Bits needed to hold max_val, never less than one.
  function automatic int unsigned width_for(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/adjust_control_debounce.sv
// rtl/adjust_control_debounce.sv - two-flop synchronizer plus mismatch-run debounce for one button
module button_debounce
  import adjust_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic raw_i,
  output logic level_o
);

  localparam int unsigned CNT_W = width_for(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any sample that agrees with the current level restarts the run.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/adjust_control.sv
// rtl/adjust_control.sv - debounced plus/minus steering with hold auto-repeat and dual-press lockout
module adjust_control
  import adjust_pkg::*;
#(
  parameter int unsigned NUM_TARGETS     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES     = 20,
  parameter int unsigned REPEAT_CYCLES   = 5,
  parameter int unsigned SEL_W           = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   plus_i,
  input  logic                   minus_i,
  input  logic [SEL_W-1:0]       sel_i,
  input  logic                   repeat_en_i,
  output logic [NUM_TARGETS-1:0] inc_pulse_o,
  output logic [NUM_TARGETS-1:0] dec_pulse_o,
  output logic                   busy_o
);

  localparam int unsigned MAX_LOAD = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES - 1
                                                                   : REPEAT_CYCLES - 1;
  localparam int unsigned CNT_W = width_for(MAX_LOAD);
  localparam logic [CNT_W-1:0]       HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]       REP_LOAD  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [NUM_TARGETS-1:0] ONE_HOT0  = NUM_TARGETS'(1);
  localparam logic [SEL_W:0]         SEL_LIMIT = NUM_TARGETS[SEL_W:0];

  logic p, m;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_plus (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .raw_i   (plus_i),
    .level_o (p)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_minus (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .raw_i   (minus_i),
    .level_o (m)
  );

  adj_state_e             state_q, state_d;
  adj_dir_e               dir_q, dir_d;
  logic [SEL_W-1:0]       tgt_q, tgt_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_TARGETS-1:0] inc_q, inc_d, dec_q, dec_d;
  logic                   fire, sel_ok, act_btn, oth_btn;

  // Widened compare keeps the range check meaningful when NUM_TARGETS is a power of two.
  assign sel_ok  = {1'b0, sel_i} < SEL_LIMIT;
  assign act_btn = (dir_q == DIR_DEC) ? m : p;
  assign oth_btn = (dir_q == DIR_DEC) ? p : m;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (p && m) begin
          state_d = ST_LOCK;
        end else if (p || m) begin
          tgt_d = sel_i;
          dir_d = m ? DIR_DEC : DIR_INC;
          if (sel_ok) begin
            fire    = 1'b1;
            cnt_d   = HOLD_LOAD;
            state_d = ST_HOLD;
          end else begin
            state_d = ST_LOCK;
          end
        end
      end
      ST_HOLD, ST_REPEAT: begin
        if (!act_btn) begin
          state_d = ST_IDLE;
        end else if (oth_btn) begin
          state_d = ST_LOCK;
        end else if (repeat_en_i) begin
          if (cnt_q == '0) begin
            fire    = 1'b1;
            cnt_d   = REP_LOAD;
            state_d = ST_REPEAT;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_LOCK: begin
        if (!p && !m) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    inc_d = (fire && dir_d == DIR_INC) ? (ONE_HOT0 << tgt_d) : '0;
    dec_d = (fire && dir_d == DIR_DEC) ? (ONE_HOT0 << tgt_d) : '0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_INC;
      tgt_q   <= '0;
      cnt_q   <= '0;
      inc_q   <= '0;
      dec_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
    end
  end

  assign inc_pulse_o = inc_q;
  assign dec_pulse_o = dec_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adjust_control.sv
// tb/tb_adjust_control.sv - randomized and directed bench for adjust_control against a cycle model
module tb_adjust_control;
  import adjust_pkg::*;

  localparam int NT   = 2;
  localparam int DB   = 4;
  localparam int HOLD = 20;
  localparam int REP  = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          plus, minus, repeat_en;
  logic [0:0]    sel;
  logic [NT-1:0] inc, dec;
  logic          busy;
  logic          plus3, minus3;
  logic [1:0]    sel3;
  logic [2:0]    inc3, dec3;
  logic          busy3;

  always #5 clk = ~clk;

  adjust_control #(.NUM_TARGETS(NT), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD),
                   .REPEAT_CYCLES(REP)) dut (
    .clk_i(clk), .reset_i(reset), .plus_i(plus), .minus_i(minus), .sel_i(sel),
    .repeat_en_i(repeat_en), .inc_pulse_o(inc), .dec_pulse_o(dec), .busy_o(busy)
  );

  adjust_control #(.NUM_TARGETS(3), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD),
                   .REPEAT_CYCLES(REP)) dut3 (
    .clk_i(clk), .reset_i(reset), .plus_i(plus3), .minus_i(minus3), .sel_i(sel3),
    .repeat_en_i(repeat_en), .inc_pulse_o(inc3), .dec_pulse_o(dec3), .busy_o(busy3)
  );

  int n_checks = 0, n_fail = 0, cyc = 0;
  int pulse_cnt, first_pulse, last_pulse, p3_cnt, first3;
  logic [2:0] last_inc3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Behavioural model: raw-sample history windows for the buttons, and an
  // elapsed-enabled-cycle count since the initial pulse for the repeat cadence.
  int hp[$], hm[$];
  bit lp, lm, mdec;
  int mode;  // 0 idle, 1 pressed, 2 locked
  int mtgt, elapsed;
  logic [NT-1:0] exp_inc, exp_dec;

  function automatic bit window_differs(input int h[$], input bit lvl);
    for (int k = 0; k <= DB; k++)
      if (h[h.size() - 2 - k] == int'(lvl)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    hp = {}; hm = {};
    for (int i = 0; i < DB + 3; i++) begin hp.push_back(0); hm.push_back(0); end
    lp = 0; lm = 0; mode = 0; exp_inc = '0; exp_dec = '0;
  endtask

  task automatic model_edge();
    bit pulse, act, oth, nlp, nlm;
    pulse = 0;
    case (mode)
      0: if (lp != lm) begin
           if (int'(sel) < NT) begin
             mode = 1; mtgt = int'(sel); mdec = lm; elapsed = 0; pulse = 1;
           end else mode = 2;
         end else if (lp && lm) mode = 2;
      1: begin
           act = mdec ? lm : lp;
           oth = mdec ? lp : lm;
           if (!act) mode = 0;
           else if (oth) mode = 2;
           else if (repeat_en) begin
             elapsed++;
             pulse = (elapsed == HOLD) || (elapsed > HOLD && (elapsed - HOLD) % REP == 0);
           end
         end
      default: if (!lp && !lm) mode = 0;
    endcase
    exp_inc = (pulse && !mdec) ? NT'(1) << mtgt : '0;
    exp_dec = (pulse &&  mdec) ? NT'(1) << mtgt : '0;
    nlp = window_differs(hp, lp) ? !lp : lp;
    nlm = window_differs(hm, lm) ? !lm : lm;
    lp = nlp; lm = nlm;
    hp.push_back(int'(plus)); hm.push_back(int'(minus));
    if (hp.size() > 32) begin void'(hp.pop_front()); void'(hm.pop_front()); end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (reset) model_reset(); else model_edge();
    @(negedge clk);
    check("inc", 32'(inc), 32'(exp_inc));
    check("dec", 32'(dec), 32'(exp_dec));
    check("busy", 32'(busy), 32'(mode != 0));
    if ((inc | dec) != '0) begin
      pulse_cnt++;
      if (first_pulse < 0) first_pulse = cyc;
      last_pulse = cyc;
    end
    if ((inc3 | dec3) != '0) begin
      p3_cnt++;
      last_inc3 = inc3;
      if (first3 < 0) first3 = cyc;
    end
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr();
    pulse_cnt = 0; first_pulse = -1; last_pulse = -1; p3_cnt = 0; first3 = -1; last_inc3 = '0;
  endtask

  int start, base_p, base_m, len;

  initial begin
    plus = 0; minus = 0; sel = '0; repeat_en = 1;
    plus3 = 0; minus3 = 0; sel3 = '0;
    clr();
    model_reset();
    reset = 1;
    #1;
    check("reset_inc", 32'(inc), 0);
    check("reset_dec", 32'(dec), 0);
    check("reset_busy", 32'(busy), 0);
    hold(3);
    reset = 0;
    hold(3);

    // Bounce shorter than the debounce window.
    clr(); plus = 1; sel = 1'(TGT_TIME);
    hold(3); plus = 0; hold(12);
    check("short_pulses", pulse_cnt, 0);

    // Single press: latency and no repeat.
    clr(); plus = 1; sel = 1'(TGT_ALARM); start = cyc + 1;
    hold(10); plus = 0; hold(14);
    check("single_count", pulse_cnt, 1);
    check("single_latency", first_pulse, start + DB + 3);
    check("single_idle", 32'(busy), 0);

    // Long hold with auto-repeat and sel toggling.
    clr(); minus = 1; sel = 1'(TGT_TIME); start = cyc + 1;
    for (int i = 0; i < 60; i++) begin tick(); sel = ~sel; end
    minus = 0; hold(14);
    check("repeat_count", pulse_cnt, 9);
    check("repeat_first", first_pulse, start + 7);
    check("repeat_last", last_pulse, start + 7 + HOLD + 7 * REP);

    // Same hold, repeat disabled.
    clr(); minus = 1; repeat_en = 0;
    hold(60); minus = 0; hold(14); repeat_en = 1;
    check("norepeat_count", pulse_cnt, 1);

    // Dual press lockout.
    clr(); plus = 1; sel = 1'(TGT_TIME);
    hold(12); minus = 1; hold(30);
    check("lock_count", pulse_cnt, 1);
    check("lock_busy", 32'(busy), 1);
    plus = 0; hold(12);
    check("lock_one_held", 32'(busy), 1);
    minus = 0; hold(12);
    check("lock_released", 32'(busy), 0);
    clr(); plus = 1; start = cyc + 1; hold(10); plus = 0; hold(14);
    check("after_lock_count", pulse_cnt, 1);
    check("after_lock_latency", first_pulse, start + 7);

    // Out-of-range target on a 3-target instance, then a valid one.
    clr(); sel3 = 2'd3; plus3 = 1; hold(15);
    check("oor_busy", 32'(busy3), 1);
    check("oor_pulses", p3_cnt, 0);
    plus3 = 0; hold(14);
    check("oor_release", 32'(busy3), 0);
    clr(); sel3 = 2'd2; plus3 = 1; start = cyc + 1; hold(10); plus3 = 0; hold(14);
    check("t3_count", p3_cnt, 1);
    check("t3_vector", 32'(last_inc3), 32'h4);
    check("t3_latency", first3, start + 7);

    // Asynchronous reset while repeating, button still held.
    clr(); plus = 1; sel = 1'(TGT_TIME); start = cyc + 1;
    while (cyc < start + 7 + HOLD + REP) tick();
    check("pre_reset_inc", 32'(inc), 1);
    #2 reset = 1;
    #1;
    check("async_inc", 32'(inc), 0);
    check("async_busy", 32'(busy), 0);
    hold(2);
    reset = 0;
    clr(); start = cyc + 1;
    hold(10); plus = 0; hold(14);
    check("post_reset_latency", first_pulse, start + 7);
    check("post_reset_count", pulse_cnt, 1);

    // Randomized segments with occasional one-cycle glitches.
    for (int seg = 0; seg < 40; seg++) begin
      base_p = ($urandom_range(0, 2) == 0) ? 1 : 0;
      base_m = ($urandom_range(0, 3) == 0) ? 1 : 0;
      len = $urandom_range(1, 45);
      for (int i = 0; i < len; i++) begin
        plus  = 1'(base_p) ^ ($urandom_range(0, 24) == 0);
        minus = 1'(base_m) ^ ($urandom_range(0, 24) == 0);
        sel = 1'($urandom);
        repeat_en = ($urandom_range(0, 9) != 0);
        tick();
      end
    end
    plus = 0; minus = 0; hold(16);
    check("final_idle", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
